// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit -- fetch stage in front of the control unit.
// Owns the PC, keeps at most one instruction-memory request in flight, and
// captures returned words into the IF/ID register. A one-word skid buffer
// (hold_buf) absorbs a response that arrives while decode is stalled.
// Build option IFU_MISALIGN_TRAP_EN: a misaligned redirect target raises a
// sticky misaligned_fault and parks the unit in HALT until reset. Without the
// macro, redirect targets are word-aligned by clearing bits [1:0].
module instruction_fetch_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            id_stall,
  output logic            if_id_valid,
  output logic [31:0]     if_id_instr,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc_plus4,
  output logic [6:0]      opcode
`ifdef IFU_MISALIGN_TRAP_EN
  ,
  output logic            misaligned_fault
`endif
);

`ifdef IFU_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;
`endif

  localparam logic [XLEN-1:0] FOUR      = XLEN'(4);
  localparam logic [XLEN-1:0] WORD_MASK = ~(XLEN'(3));

  state_t          state;
  logic [XLEN-1:0] pc;
  logic            kill;       // in-flight response belongs to a stale PC
  logic [31:0]     hold_buf;   // word returned while IF/ID was stalled

  logic            handshake;
  logic            slot_free;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] redirect_pc;
  logic            load_en;
  logic [31:0]     load_instr;

  assign imem_req_valid = (state == S_REQ);
  assign imem_addr      = pc;
  assign opcode         = if_id_instr[6:0];
  assign handshake      = imem_req_valid && imem_req_ready;
  assign slot_free      = !if_id_valid || !id_stall;
  assign pc_plus4       = pc + FOUR;

`ifdef IFU_MISALIGN_TRAP_EN
  logic trap;
  // A misaligned target is never loaded into the PC; it halts the unit instead.
  assign redirect_pc = redirect_target;
  assign trap        = redirect_valid && (redirect_target[1:0] != 2'b00) &&
                       (state != S_HALT);
`else
  assign redirect_pc = redirect_target & WORD_MASK;
`endif

  // Pick whether a word enters IF/ID this cycle, and from where
  always_comb begin
    load_en    = 1'b0;
    load_instr = imem_rsp_data;
    case (state)
      S_WAIT: begin
        if (imem_rsp_valid && !kill && !redirect_valid && slot_free) begin
          load_en = 1'b1;
        end
      end
      S_HOLD: begin
        if (!redirect_valid && !id_stall) begin
          load_en    = 1'b1;
          load_instr = hold_buf;
        end
      end
      default: begin
        load_en = 1'b0;
      end
    endcase
  end

  // Fetch sequencer: PC update, request/response tracking and skid buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      kill     <= 1'b0;
      hold_buf <= NOP_INSTR;
`ifdef IFU_MISALIGN_TRAP_EN
      misaligned_fault <= 1'b0;
`endif
    end else begin
`ifdef IFU_MISALIGN_TRAP_EN
      if (trap) begin
        misaligned_fault <= 1'b1;
        kill             <= 1'b0;
        state            <= S_HALT;
      end else
`endif
      begin
        case (state)
          S_REQ: begin
            if (redirect_valid) begin
              pc <= redirect_pc;
              if (handshake) begin
                // The accepted request still carries the old PC.
                kill  <= 1'b1;
                state <= S_WAIT;
              end
            end else if (handshake) begin
              state <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (imem_rsp_valid) begin
              state <= S_REQ;
              kill  <= 1'b0;
              if (redirect_valid) begin
                // Response and redirect together: drop the word, restart.
                pc <= redirect_pc;
              end else if (!kill) begin
                if (slot_free) begin
                  pc <= pc_plus4;
                end else begin
                  hold_buf <= imem_rsp_data;
                  state    <= S_HOLD;
                end
              end
            end else if (redirect_valid) begin
              pc   <= redirect_pc;
              kill <= 1'b1;
            end
          end
          S_HOLD: begin
            if (redirect_valid) begin
              pc       <= redirect_pc;
              hold_buf <= NOP_INSTR;
              state    <= S_REQ;
            end else if (!id_stall) begin
              pc    <= pc_plus4;
              state <= S_REQ;
            end
          end
`ifdef IFU_MISALIGN_TRAP_EN
          S_HALT: begin
            state <= S_HALT;
          end
`endif
          default: begin
            state <= S_REQ;
          end
        endcase
      end
    end
  end

  // IF/ID register: redirect flush, new word load, stall hold, else bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_id_valid    <= 1'b0;
      if_id_instr    <= NOP_INSTR;
      if_id_pc       <= '0;
      if_id_pc_plus4 <= '0;
    end else if (redirect_valid) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
    end else if (load_en) begin
      if_id_valid    <= 1'b1;
      if_id_instr    <= load_instr;
      if_id_pc       <= pc;
      if_id_pc_plus4 <= pc_plus4;
    end else if (!id_stall) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit -- randomized bench for instruction_fetch_unit.
// Memory returns a hash of the address; the reference model is the program
// order stream: start at reset PC, +4 per instruction consumed by decode,
// restart at the (word-aligned) target after each redirect.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        id_stall;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic [6:0]  opcode;
`ifdef IFU_MISALIGN_TRAP_EN
  logic        misaligned_fault;
`endif

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .id_stall        (id_stall),
    .if_id_valid     (if_id_valid),
    .if_id_instr     (if_id_instr),
    .if_id_pc        (if_id_pc),
    .if_id_pc_plus4  (if_id_pc_plus4),
    .opcode          (opcode)
`ifdef IFU_MISALIGN_TRAP_EN
    ,
    .misaligned_fault(misaligned_fault)
`endif
  );

  localparam logic [31:0] NOP = 32'h0000_0013;

  int          tests = 0;
  int          fails = 0;
  int          hs_count = 0;
  int          consumed = 0;
  int          cyc = 0;
  int          last_cyc = 0;
  int          dly = 0;
  bit          fast = 1'b1;
  bit          steady = 1'b0;
  bit          last_steady = 1'b0;
  bit          flush_chk = 1'b0;
  bit          hold_chk = 1'b0;
  bit          pend = 1'b0;
  logic [31:0] last_hs_addr = '0;
  logic [31:0] paddr = '0;
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] redir_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output bit found);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (if_id_valid) begin
        found = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic wait_hs(input int base, output bit found);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (hs_count > base) begin
        found = 1'b1;
        break;
      end
      step();
    end
  endtask

  // Memory model: one-word responses after 1..3 cycles, random ready
  initial begin : mem_model
    bit          hs;
    logic [31:0] a;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      hs = !rst && imem_req_valid && imem_req_ready;
      a  = imem_addr;
      if (hs) begin
        hs_count++;
        last_hs_addr = a;
      end
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (hs) begin
          check("one_outstanding", 32'(pend), 32'd0);
          pend  = 1'b1;
          paddr = a;
          dly   = fast ? 0 : int'($urandom_range(0, 2));
        end
        if (pend) begin
          if (dly == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(paddr);
            pend = 1'b0;
          end else begin
            dly--;
          end
        end
      end
      imem_req_ready = fast ? 1'b1 : ($urandom_range(0, 9) < 7);
    end
  end

  // Monitor: compares IF/ID against the program-order stream model
  initial begin : monitor
    logic [31:0] w;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (flush_chk) begin
          check("flush_valid", 32'(if_id_valid), 32'd0);
          check("flush_instr", if_id_instr, NOP);
        end
        if (hold_chk) begin
          check("stall_hold_valid", 32'(if_id_valid), 32'd1);
        end
        if (if_id_valid) begin
          w = mem_word(exp_pc);
          check("if_id_pc", if_id_pc, exp_pc);
          check("if_id_instr", if_id_instr, w);
          check("if_id_pc_plus4", if_id_pc_plus4, exp_pc + 32'd4);
          check("opcode", 32'(opcode), 32'(w[6:0]));
        end else begin
          check("bubble_instr", if_id_instr, NOP);
          check("bubble_opcode", 32'(opcode), 32'h13);
        end
        flush_chk = redirect_valid;
        hold_chk  = id_stall && if_id_valid && !redirect_valid;
        if (redirect_valid) begin
          if (redir_q.size() > 0) exp_pc = redir_q.pop_front();
        end else if (if_id_valid && !id_stall) begin
          $display("[TB] consumed pc=%h instr=%h", if_id_pc, if_id_instr);
          if (steady && last_steady) check("throughput_gap", 32'(cyc - last_cyc), 32'd2);
          last_cyc    = cyc;
          last_steady = steady;
          consumed++;
          exp_pc = exp_pc + 32'd4;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Stimulus: directed scenarios, then randomized stall/redirect traffic
  initial begin : stim
    logic [31:0] t;
    logic [31:0] a_pc;
    int          h0;
    bit          found;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_target = '0;
    id_stall = 1'b0;
    fast = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(if_id_valid), 32'd0);
    check("rst_instr", if_id_instr, NOP);
    check("rst_if_id_pc", if_id_pc, 32'd0);
    check("rst_pc_plus4", if_id_pc_plus4, 32'd0);
    check("rst_req_valid", 32'(imem_req_valid), 32'd1);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_opcode", 32'(opcode), 32'h13);
`ifdef IFU_MISALIGN_TRAP_EN
    check("rst_fault", 32'(misaligned_fault), 32'd0);
`endif
    step();
    rst = 1'b0;
    steady = 1'b1;
    repeat (20) step();
    steady = 1'b0;

    // Decode stall while the next response arrives
    wait_valid(found);
    check("stall_found_valid", 32'(found), 32'd1);
    a_pc = exp_pc;
    id_stall = 1'b1;
    h0 = hs_count;
    repeat (5) step();
    check("stall_one_req", 32'(hs_count - h0), 32'd1);
    check("stall_still_valid", 32'(if_id_valid), 32'd1);
    id_stall = 1'b0;
    step();
    check("stall_release_valid", 32'(if_id_valid), 32'd1);
    check("stall_release_pc", if_id_pc, a_pc + 32'd4);
    check("stall_release_addr", imem_addr, a_pc + 32'd8);

    // Redirect coinciding with a request handshake
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req_valid) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("redir_found_req", 32'(found), 32'd1);
    redirect_valid = 1'b1;
    redirect_target = 32'h100;
    redir_q.push_back(32'h100);
    step();
    redirect_valid = 1'b0;
    h0 = hs_count;
    wait_hs(h0, found);
    check("redir_found_hs", 32'(found), 32'd1);
    check("redir_next_addr", last_hs_addr, 32'h100);
    wait_valid(found);
    check("redir_found_load", 32'(found), 32'd1);
    check("redir_first_pc", if_id_pc, 32'h100);

    // Redirect overrides a stall on a live IF/ID entry
    id_stall = 1'b1;
    step();
    check("stall_redir_held", 32'(if_id_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_target = 32'h200;
    redir_q.push_back(32'h200);
    step();
    redirect_valid = 1'b0;
    check("stall_redir_valid", 32'(if_id_valid), 32'd0);
    check("stall_redir_instr", if_id_instr, NOP);
    id_stall = 1'b0;

    // PC wrap-around at the top of the address space
    redirect_valid = 1'b1;
    redirect_target = 32'hFFFF_FFF8;
    redir_q.push_back(32'hFFFF_FFF8);
    step();
    redirect_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (if_id_valid && if_id_pc == 32'hFFFF_FFFC) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("wrap_found", 32'(found), 32'd1);
    check("wrap_pc_plus4", if_id_pc_plus4, 32'h0);
    check("wrap_next_addr", imem_addr, 32'h0);

    // Randomized traffic
    fast = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      step();
      id_stall = ($urandom_range(0, 9) < 3);
      redirect_valid = ($urandom_range(0, 99) < 5);
      if (redirect_valid) begin
        if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        else t = $urandom & 32'h0000_3FFF;
`ifdef IFU_MISALIGN_TRAP_EN
        t[1:0] = 2'b00;
`endif
        redirect_target = t;
        redir_q.push_back(t & 32'hFFFF_FFFC);
      end
    end
    step();
    redirect_valid = 1'b0;
    id_stall = 1'b0;
    fast = 1'b1;
    repeat (20) step();

    // Misaligned redirect target
    redirect_valid = 1'b1;
    redirect_target = 32'h102;
    redir_q.push_back(32'h100);
    step();
    redirect_valid = 1'b0;
    h0 = hs_count;
`ifdef IFU_MISALIGN_TRAP_EN
    check("misalign_fault", 32'(misaligned_fault), 32'd1);
    for (int i = 0; i < 8; i++) begin
      check("misalign_halt_req", 32'(imem_req_valid), 32'd0);
      step();
    end
`else
    wait_hs(h0, found);
    check("misalign_found_hs", 32'(found), 32'd1);
    check("misalign_aligned_addr", last_hs_addr, 32'h100);
`endif

    check("liveness", 32'(consumed > 50), 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage directly upstream of the control unit. Owns the program counter and issues one word-aligned request at a time to instruction memory.
- Captures each returned word into the IF/ID pipeline register. Presents the word's opcode field to the control unit and the full word, PC and PC+4 to decode.
- Handles decode back-pressure (stall) and redirects from branch/jump resolution (flush).

Parameters:
- XLEN, 32, width of PC and addresses
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0013, word placed in IF/ID when empty or flushed (addi x0,x0,0)

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  asynchronous, active-high reset
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request this cycle
- imem_addr  output  XLEN  fetch address (= pc)
- imem_rsp_valid  input  1  response word valid (one cycle pulse)
- imem_rsp_data  input  32  response instruction word
- redirect_valid  input  1  taken branch/jal/jalr resolved downstream
- redirect_target  input  XLEN  new PC
- id_stall  input  1  decode cannot accept a new instruction
- if_id_valid  output  1  IF/ID holds a live instruction
- if_id_instr  output  32  IF/ID instruction word
- if_id_pc  output  XLEN  PC of that instruction
- if_id_pc_plus4  output  XLEN  if_id_pc + 4, used as link value
- opcode  output  7  if_id_instr[6:0], combinational, drives control unit

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_PC; state=REQ; kill=0; hold_buf=NOP_INSTR.
  - if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc_plus4=0.
- Request outputs are combinational from state: imem_req_valid=1 only in REQ; imem_addr=pc at all times.
- At most one outstanding request.
- Memory samples the address only on a handshake (valid&&ready). The address may change while valid is unaccepted, but only on redirect.
- PC arithmetic is modulo 2^XLEN; pc=FFFF_FFFC advances to 0000_0000.
- State REQ:
  - Handshake -> WAIT.
  - Redirect in the same cycle as the handshake -> pc<=target, kill<=1, go WAIT. The in-flight word belongs to the old pc.
  - Redirect with no handshake -> pc<=target, stay REQ.
- State WAIT, on rsp_valid:
  - kill=1 -> discard the word, kill<=0, go REQ.
  - Else, if slot free (!if_id_valid || !id_stall) -> load IF/ID (valid=1, instr=data, pc=pc, pc_plus4=pc+4), pc<=pc+4, go REQ.
  - Else -> hold_buf<=data, go HOLD.
- WAIT with redirect: pc<=target and kill<=1, unless rsp_valid arrives in the same cycle. In that case the word is discarded, kill stays 0, and the state goes to REQ.
- State HOLD:
  - !id_stall -> load IF/ID from hold_buf, pc<=pc+4, go REQ.
  - Redirect -> drop hold_buf, pc<=target, go REQ.
- IF/ID register:
  - Redirect has highest priority and overrides id_stall: if_id_valid<=0, if_id_instr<=NOP_INSTR, in the same cycle as redirect_valid.
  - id_stall && if_id_valid -> all IF/ID fields hold.
  - !id_stall with no new word loading -> if_id_valid<=0 and if_id_instr<=NOP_INSTR, so the control unit decodes a bubble.
- Throughput: minimum latency is request handshake -> response -> IF/ID load on the response edge. With a 1-cycle memory the sustained rate is one instruction per 2 cycles.
- Redirect during reset is ignored. Reset mid-transaction abandons any outstanding response. A response arriving in REQ state is ignored.

Optional Feature:
- Macro: IFU_MISALIGN_TRAP_EN.
- When defined:
  - Adds output misaligned_fault (1 bit, reset 0).
  - A redirect_target with [1:0]!=0 sets misaligned_fault=1 (sticky until reset), forces state to an extra HALT state with imem_req_valid=0, and flushes IF/ID.
- When undefined:
  - There is no port and no HALT state.
  - redirect_target[1:0] is forced to 2'b00 before loading pc.

Test Plan:
- Reset release, ready=1, 1-cycle memory returning addr-based words -> imem_addr sequence 0,4,8,C. if_id_pc follows 0,4,8 with if_id_valid pulses, and opcode = word[6:0].
- id_stall=1 for 5 cycles while a response arrives -> state HOLD. IF/ID unchanged and no new request issued. On stall release the held word loads next edge and pc advances by 4.
- Redirect to 0x100 in the same cycle as the REQ handshake for 0x8 -> the response for 0x8 is discarded, the next request addr=0x100, and the first loaded if_id_pc=0x100.
- Redirect while id_stall=1 and if_id_valid=1 -> if_id_valid=0 and if_id_instr=0x0000_0013 next edge. Stall override is confirmed.
- pc=0xFFFF_FFFC fetched -> if_id_pc_plus4=0x0000_0000 and next imem_addr=0x0.
- With IFU_MISALIGN_TRAP_EN, redirect to 0x102 -> misaligned_fault=1, imem_req_valid stays 0 until rst. Without the macro, the next imem_addr=0x100.
